// File: rtl/lms_conv_monitor.sv
// LMS convergence monitor: saturated error, windowed MSE and a
// convergence / divergence state machine for an adaptive filter.
module lms_conv_monitor #(
  parameter int          WIDTH       = 16,
  parameter int          WIN_LOG2    = 4,
  parameter logic [31:0] CONV_THRESH = 32'd256,
  parameter logic [31:0] DIV_THRESH  = 32'h0100_0000,
  parameter int          HOLD        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] d,
  input  logic signed [WIDTH-1:0] y,
  output logic signed [WIDTH-1:0] err,
  output logic [31:0]             mse,
  output logic                    mse_valid,
  output logic [1:0]              state,
  output logic                    converged,
  output logic                    diverged,
  output logic [15:0]             win_count
);

  localparam int ACC_W = 32 + WIN_LOG2;
  localparam int CNT_W = WIN_LOG2;
  localparam int GW    = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TRK  = 2'b01,
    S_CONV = 2'b10,
    S_DIV  = 2'b11
  } state_e;

  logic signed [WIDTH-1:0] err_q, err_d;
  logic                    en_d_q, en_d_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             mse_q, mse_d;
  logic                    mv_q, mv_d;
  logic [15:0]             wc_q, wc_d;
  logic [GW-1:0]           good_q, good_d;
  state_e                  state_q, state_d;

  logic [WIDTH:0]            diff;
  logic signed [WIDTH-1:0]   err_sat;
  logic signed [2*WIDTH-1:0] sq;
  logic [ACC_W-1:0]          sum;
  logic [31:0]               mse_new;
  logic                      close;
  logic [GW-1:0]             good_inc;

  // Stage-1 arithmetic: widened difference clamped to the sample range
  always_comb begin
    diff = {d[WIDTH-1], d} - {y[WIDTH-1], y};
    if (diff[WIDTH] ^ diff[WIDTH-1]) begin
      err_sat = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      err_sat = diff[WIDTH-1:0];
    end
  end

  // Stage-2 arithmetic: signed square never overflows, even for the min value
  always_comb begin
    sq       = err_q * err_q;
    sum      = acc_q + ACC_W'($unsigned(sq));
    mse_new  = 32'(sum >> WIN_LOG2);
    close    = en_d_q && (cnt_q == {CNT_W{1'b1}});
    good_inc = (good_q == GW'(HOLD)) ? good_q : good_q + 1'b1;
  end

  // Next-state logic for pipeline, window accumulator and FSM
  always_comb begin
    err_d   = err_q;
    en_d_d  = 1'b0;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mse_d   = mse_q;
    mv_d    = 1'b0;
    wc_d    = wc_q;
    good_d  = good_q;
    state_d = state_q;
    if (clear) begin
      err_d   = '0;
      acc_d   = '0;
      cnt_d   = '0;
      mse_d   = '0;
      wc_d    = '0;
      good_d  = '0;
      state_d = S_IDLE;
    end else begin
      if (en) begin
        err_d  = err_sat;
        en_d_d = 1'b1;
      end
      if (en_d_q) begin
        if (close) begin
          mse_d = mse_new;
          mv_d  = 1'b1;
          acc_d = '0;
          cnt_d = '0;
          if (wc_q != 16'hFFFF) begin
            wc_d = wc_q + 16'd1;
          end
          if (state_q != S_DIV) begin
            if (mse_new > DIV_THRESH) begin
              state_d = S_DIV;
            end else if (mse_new <= CONV_THRESH) begin
              good_d  = good_inc;
              state_d = (good_inc == GW'(HOLD)) ? S_CONV : S_TRK;
            end else begin
              good_d  = '0;
              state_d = S_TRK;
            end
          end
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q   <= '0;
      en_d_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mse_q   <= '0;
      mv_q    <= 1'b0;
      wc_q    <= '0;
      good_q  <= '0;
      state_q <= S_IDLE;
    end else begin
      err_q   <= err_d;
      en_d_q  <= en_d_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mse_q   <= mse_d;
      mv_q    <= mv_d;
      wc_q    <= wc_d;
      good_q  <= good_d;
      state_q <= state_d;
    end
  end

  assign err       = err_q;
  assign mse       = mse_q;
  assign mse_valid = mv_q;
  assign state     = state_q;
  assign converged = (state_q == S_CONV);
  assign diverged  = (state_q == S_DIV);
  assign win_count = wc_q;

endmodule

// File: tb/tb_lms_conv_monitor.sv
// Bench for lms_conv_monitor: random stimulus, window-level
// reference model and a queue-based scoreboard.
module tb_lms_conv_monitor;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] d = '0;
  logic signed [15:0] y = '0;
  logic signed [15:0] err;
  logic [31:0]        mse;
  logic               mse_valid;
  logic [1:0]         state;
  logic               converged;
  logic               diverged;
  logic [15:0]        win_count;

  lms_conv_monitor dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .d(d), .y(y), .err(err), .mse(mse),
    .mse_valid(mse_valid), .state(state),
    .converged(converged), .diverged(diverged),
    .win_count(win_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int     cyc;
    longint mse;
    int     st;
    int     wc;
  } win_t;
  typedef struct {
    int cyc;
    int val;
  } err_t;

  win_t   wq[$];
  err_t   eq[$];
  longint win[$];
  bit     pend = 0;
  int     pend_e = 0;
  int     m_st = 0;
  int     m_good = 0;
  int     m_wc = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampf(int a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // Block average of 16 squared errors plus the state rules
  task automatic close_win(int c);
    longint s = 0;
    win_t   w;
    foreach (win[i]) s += win[i];
    w.mse = s / 16;
    win.delete();
    if (m_wc < 65535) m_wc++;
    if (m_st != 3) begin
      if (w.mse > 64'h0100_0000) begin
        m_st = 3;
      end else if (w.mse <= 256) begin
        m_good = (m_good >= 4) ? 4 : m_good + 1;
        m_st = (m_good == 4) ? 2 : 1;
      end else begin
        m_good = 0;
        m_st = 1;
      end
    end
    w.cyc = c;
    w.st  = m_st;
    w.wc  = m_wc;
    wq.push_back(w);
  endtask

  // Drive one cycle; the sample enters the window one edge after capture
  task automatic step(bit e, bit cl, int dv, int yv);
    err_t x;
    if (cl) begin
      win.delete();
      pend   = 0;
      m_st   = 0;
      m_good = 0;
      m_wc   = 0;
      x.cyc = cyc + 1;
      x.val = 0;
      eq.push_back(x);
    end else begin
      if (pend) begin
        win.push_back(longint'(pend_e) * pend_e);
        if (win.size() == 16) close_win(cyc + 1);
      end
      pend = e;
      if (e) begin
        pend_e = clampf(dv - yv);
        x.cyc = cyc + 1;
        x.val = pend_e;
        eq.push_back(x);
      end
    end
    en    = e;
    clear = cl;
    d     = dv[15:0];
    y     = yv[15:0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, " err"}, longint'(err), 0);
    chk({tag, " mse"}, longint'(mse), 0);
    chk({tag, " mse_valid"}, longint'(mse_valid), 0);
    chk({tag, " state"}, longint'(state), 0);
    chk({tag, " converged"}, longint'(converged), 0);
    chk({tag, " diverged"}, longint'(diverged), 0);
    chk({tag, " win_count"}, longint'(win_count), 0);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    #1;
    check_zero("async_rst");
    win.delete();
    pend   = 0;
    m_st   = 0;
    m_good = 0;
    m_wc   = 0;
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (rst) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("missed mse_valid", 0, 1);
        void'(wq.pop_front());
      end
      if (mse_valid) begin
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          win_t w;
          w = wq.pop_front();
          chk("mse", longint'(mse), w.mse);
          chk("state", longint'(state), w.st);
          chk("win_count", longint'(win_count), w.wc);
          chk("converged", longint'(converged), (w.st == 2) ? 1 : 0);
          chk("diverged", longint'(diverged), (w.st == 3) ? 1 : 0);
        end else begin
          chk("unexpected mse_valid", 1, 0);
        end
      end
      while (eq.size() > 0 && eq[0].cyc < cyc) begin
        chk("missed err check", 0, 1);
        void'(eq.pop_front());
      end
      if (eq.size() > 0 && eq[0].cyc == cyc) begin
        err_t x;
        x = eq.pop_front();
        chk("err", longint'(err), x.val);
      end
    end
  end

  initial begin
    int b;
    int r;
    bit e;
    #2;
    check_zero("por");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Zero-error stream: four windows, converge on the fourth
    b = int'($urandom_range(0, 20000)) - 10000;
    repeat (64) step(1, 0, b, b);
    idle(3);

    // One bad window then four good ones to reconverge
    b = int'($urandom_range(0, 20000)) - 10000;
    repeat (16) step(1, 0, b + 100, b);
    idle(2);
    repeat (64) step(1, 0, b, b);
    idle(3);

    // Constant error of 1000
    repeat (16) step(1, 0, 1000, 0);
    idle(3);

    // Random near-threshold errors with gaps in en
    repeat (500) begin
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0) ? 40 : 12;
      b = int'($urandom_range(0, 60000)) - 30000;
      step(e, 0, b + int'($urandom_range(0, 2 * r)) - r, b);
    end
    idle(3);

    // Strobe every third cycle; clear with en on sample 8
    step(0, 1, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(1, 0, 4, 0);
      idle(2);
    end
    step(1, 1, 4, 0);
    idle(2);
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 4, 0);
      idle(2);
    end
    idle(3);

    // Random traffic with occasional clears
    repeat (300) begin
      b = int'($urandom_range(0, 2000)) - 1000;
      step($urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0,
           b + int'($urandom_range(0, 30)) - 15, b);
    end
    idle(3);

    // Saturation both ways, divergence is sticky, clear recovers
    repeat (16) step(1, 0, 32767, -32768);
    idle(2);
    repeat (16) step(1, 0, -32768, 32767);
    idle(2);
    b = int'($urandom_range(0, 1000));
    repeat (64) step(1, 0, b, b);
    idle(3);
    chk("sticky diverged", longint'(diverged), 1);
    step(0, 1, 0, 0);
    idle(2);
    chk("clear state", longint'(state), m_st);
    chk("clear win_count", longint'(win_count), m_wc);

    // Asynchronous reset mid-window, then a full fresh window
    b = int'($urandom_range(0, 1000));
    repeat (7) step(1, 0, b + 5, b);
    idle(1);
    do_reset();
    repeat (40) step($urandom_range(0, 1) == 1, 0, b + 3, b);
    repeat (16) step(1, 0, b + 3, b);
    idle(4);

    chk("window queue drained", wq.size(), 0);
    chk("err queue drained", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
